ysyx_23060201_mem_arb: RTL and testbench

YSYX_23060201_MEM_ARB -- requirements
Module: ysyx_23060201_mem_arb

---
 rtl/ysyx_23060201_mem_arb_pkg.sv | 28 ++
 rtl/ysyx_23060201_rr_arb2.sv | 35 +++
 rtl/ysyx_23060201_mem_arb.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_23060201_mem_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM encodings,
// transaction owner encoding, the fixed IFU read mask and default latency.
package ysyx_23060201_mem_arb_pkg;

  // Arbiter FSM encodings (also visible on the debug state output).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Instruction fetches are always full 32-bit reads.
  localparam logic [7:0] IFU_RMASK = 8'h0F;

  // Default accept-to-strobe latency in cycles (legal range 1..15).
  localparam int LATENCY_DEFAULT = 1;

  // Bit positions in the two-bit request/grant vectors.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Two-input round-robin grant selection. Bit 0 is the IFU, bit 1 the LSU.
// The last-grant register resets to the LSU so the IFU wins the first tie.
module ysyx_23060201_rr_arb2
  import ysyx_23060201_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_lsu;

  // Remember who won the most recent accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_lsu <= 1'b1;
    end else if (i_accept) begin
      r_last_lsu <= o_grant[GNT_LSU];
    end
  end

  // One-hot grant: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_lsu ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// IFU/LSU memory arbiter. One transaction at a time: IDLE accepts a request
// from the granted requester, ACCESS waits LATENCY cycles and strobes memory
// in its last cycle, RESP holds the response until the owner takes it.
//
// Handshake: a request or response transfers on a cycle where valid and
// ready are both high. Requesters hold valid (and payload) until accepted;
// req_ready depends combinationally on req_valid through the grant, never the
// other way around. resp_valid stays high with stable rdata until resp_ready.
module ysyx_23060201_mem_arb
  import ysyx_23060201_mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LATENCY        = LATENCY_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // IFU (read-only) port
  input  logic                      ifu_req_valid,
  output logic                      ifu_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] ifu_raddr,
  output logic                      ifu_resp_valid,
  input  logic                      ifu_resp_ready,
  output logic [DATA_WIDTH-1:0]     ifu_rdata,
  // LSU (read/write) port
  input  logic                      lsu_req_valid,
  output logic                      lsu_req_ready,
  input  logic                      lsu_req_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata,
  input  logic [7:0]                lsu_wmask,
  input  logic [7:0]                lsu_rmask,
  output logic                      lsu_resp_valid,
  input  logic                      lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]     lsu_rdata,
  // Memory port
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]                mem_rmask,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [7:0]                mem_wmask,
  // Debug: current FSM state
  output logic [1:0]                dbg_state
);

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_e                    r_state;
  state_e                    w_next;
  logic [3:0]                r_cnt;
  owner_e                    r_owner;
  logic                      r_wen;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [7:0]                r_wmask;
  logic [7:0]                r_rmask;
  logic [DATA_WIDTH-1:0]     r_ifu_rdata;
  logic [DATA_WIDTH-1:0]     r_lsu_rdata;

  logic [1:0]                w_req;
  logic [1:0]                w_grant;
  logic                      w_idle;
  logic                      w_accept;
  logic                      w_strobe;
  logic                      w_resp_hs;

  assign w_req = {lsu_req_valid, ifu_req_valid};

  ysyx_23060201_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Ready is masked by reset so nothing looks acceptable while rst_n is low.
  assign w_idle        = rst_n && (r_state == ST_IDLE);
  assign ifu_req_ready = w_idle && w_grant[GNT_IFU];
  assign lsu_req_ready = w_idle && w_grant[GNT_LSU];
  assign w_accept      = (ifu_req_valid && ifu_req_ready) ||
                         (lsu_req_valid && lsu_req_ready);

  // The single strobe cycle is the last ACCESS cycle.
  assign w_strobe = (r_state == ST_ACCESS) && (r_cnt == LAT_C);
  assign mem_ren  = w_strobe && !r_wen;
  assign mem_wen  = w_strobe && r_wen;

  // Memory payload comes straight from the captured request; strobes qualify it.
  assign mem_raddr = r_addr;
  assign mem_rmask = r_rmask;
  assign mem_waddr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;

  // Only the owner ever sees resp_valid; the other resp_ready is ignored.
  assign ifu_resp_valid = (r_state == ST_RESP) && (r_owner == OWN_IFU);
  assign lsu_resp_valid = (r_state == ST_RESP) && (r_owner == OWN_LSU);
  assign w_resp_hs      = (ifu_resp_valid && ifu_resp_ready) ||
                          (lsu_resp_valid && lsu_resp_ready);

  assign ifu_rdata = r_ifu_rdata;
  assign lsu_rdata = r_lsu_rdata;
  assign dbg_state = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_next = ST_ACCESS;
      ST_ACCESS: if (w_strobe)  w_next = ST_RESP;
      ST_RESP:   if (w_resp_hs) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ACCESS cycle counter: 1 in the first ACCESS cycle, strobe when it hits LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= 4'd1;
    end else if ((r_state == ST_ACCESS) && !w_strobe) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Capture the winning request at accept; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IFU;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= 8'h00;
      r_rmask <= 8'h00;
    end else if (w_accept) begin
      if (lsu_req_ready) begin
        r_owner <= OWN_LSU;
        r_wen   <= lsu_req_wen;
        r_addr  <= lsu_addr;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
        r_rmask <= lsu_rmask;
      end else begin
        r_owner <= OWN_IFU;
        r_wen   <= 1'b0;
        r_addr  <= ifu_raddr;
        r_wdata <= '0;
        r_wmask <= 8'h00;
        r_rmask <= IFU_RMASK;
      end
    end
  end

  // Load the owner's response data in the strobe cycle; writes return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else if (w_strobe) begin
      if (r_owner == OWN_IFU) begin
        r_ifu_rdata <= mem_rdata;
      end else begin
        r_lsu_rdata <= r_wen ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// Directed bench for the memory arbiter: one LATENCY=1 instance for the
// basic read/write/contention/reset scenarios and one LATENCY=3 instance
// for response back-pressure and mid-transaction reset.
module tb_ysyx_23060201_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // ---------------- LATENCY=1 instance ----------------
  logic        ifu_req_valid = 0, ifu_resp_ready = 0;
  logic        lsu_req_valid = 0, lsu_req_wen = 0, lsu_resp_ready = 0;
  logic [31:0] ifu_raddr = '0, lsu_addr = '0, lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0, lsu_rmask = '0;
  logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic        mem_ren, mem_wen;
  logic [31:0] ifu_rdata, lsu_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_rmask, mem_wmask;
  logic [1:0]  dbg_state;

  // Memory model: one fixed instruction word, otherwise inverted address.
  assign mem_rdata = (mem_raddr == 32'h8000_0000) ? 32'h0000_0413 : ~mem_raddr;

  ysyx_23060201_mem_arb #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rmask(lsu_rmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .dbg_state(dbg_state)
  );

  // ---------------- LATENCY=3 instance ----------------
  logic        s_ifu_req_valid = 0, s_ifu_resp_ready = 0;
  logic        s_lsu_req_valid = 0, s_lsu_req_wen = 0, s_lsu_resp_ready = 0;
  logic [31:0] s_ifu_raddr = '0, s_lsu_addr = '0, s_lsu_wdata = '0;
  logic [7:0]  s_lsu_wmask = '0, s_lsu_rmask = '0;
  logic        s_ifu_req_ready, s_ifu_resp_valid, s_lsu_req_ready, s_lsu_resp_valid;
  logic        s_mem_ren, s_mem_wen;
  logic [31:0] s_ifu_rdata, s_lsu_rdata, s_mem_raddr, s_mem_rdata, s_mem_waddr, s_mem_wdata;
  logic [7:0]  s_mem_rmask, s_mem_wmask;
  logic [1:0]  s_dbg_state;

  assign s_mem_rdata = ~s_mem_raddr;

  ysyx_23060201_mem_arb #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(s_ifu_req_valid), .ifu_req_ready(s_ifu_req_ready), .ifu_raddr(s_ifu_raddr),
    .ifu_resp_valid(s_ifu_resp_valid), .ifu_resp_ready(s_ifu_resp_ready), .ifu_rdata(s_ifu_rdata),
    .lsu_req_valid(s_lsu_req_valid), .lsu_req_ready(s_lsu_req_ready), .lsu_req_wen(s_lsu_req_wen),
    .lsu_addr(s_lsu_addr), .lsu_wdata(s_lsu_wdata), .lsu_wmask(s_lsu_wmask), .lsu_rmask(s_lsu_rmask),
    .lsu_resp_valid(s_lsu_resp_valid), .lsu_resp_ready(s_lsu_resp_ready), .lsu_rdata(s_lsu_rdata),
    .mem_ren(s_mem_ren), .mem_raddr(s_mem_raddr), .mem_rmask(s_mem_rmask), .mem_rdata(s_mem_rdata),
    .mem_wen(s_mem_wen), .mem_waddr(s_mem_waddr), .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask),
    .dbg_state(s_dbg_state)
  );

  // Strobe monitors: simultaneous ren/wen and back-to-back reads on each instance.
  int   both1 = 0, b2b1 = 0, both3 = 0, b2b3 = 0;
  logic prev_ren1 = 0, prev_ren3 = 0;
  always @(negedge clk) begin
    if (mem_ren && mem_wen) both1++;
    if (mem_ren && prev_ren1) b2b1++;
    prev_ren1 = mem_ren;
    if (s_mem_ren && s_mem_wen) both3++;
    if (s_mem_ren && prev_ren3) b2b3++;
    prev_ren3 = s_mem_ren;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #2;
    n_vec++; if (ifu_req_ready !== 1'b0) begin n_miss++; $display("FAIL rst_ifu_ready: got %0h want 0", ifu_req_ready); end
    n_vec++; if (lsu_req_ready !== 1'b0) begin n_miss++; $display("FAIL rst_lsu_ready: got %0h want 0", lsu_req_ready); end
    n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_miss++; $display("FAIL rst_resp_valid: got %0h want 0", {ifu_resp_valid, lsu_resp_valid}); end
    n_vec++; if ({mem_ren, mem_wen} !== 2'b00) begin n_miss++; $display("FAIL rst_strobes: got %0h want 0", {mem_ren, mem_wen}); end
    n_vec++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin n_miss++; $display("FAIL rst_rdata: got %h want 0", {ifu_rdata, lsu_rdata}); end
    n_vec++; if (mem_raddr !== 32'h0) begin n_miss++; $display("FAIL rst_mem_raddr: got %h want 0", mem_raddr); end
    n_vec++; if (dbg_state !== 2'd0) begin n_miss++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_ifu_read();
    ifu_raddr = 32'h8000_0000;
    ifu_req_valid = 1'b1;
    #1;
    n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_miss++; $display("FAIL rd_ready: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    step();
    ifu_req_valid = 1'b0;
    ifu_raddr = 32'h1234_5678;
    #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b10) begin n_miss++; $display("FAIL rd_strobe_t1: got %b want 10", {mem_ren, mem_wen}); end
    n_vec++; if (mem_raddr !== 32'h8000_0000) begin n_miss++; $display("FAIL rd_raddr: got %h want 80000000", mem_raddr); end
    n_vec++; if (mem_rmask !== 8'h0F) begin n_miss++; $display("FAIL rd_rmask: got %h want 0f", mem_rmask); end
    n_vec++; if ({ifu_req_ready, ifu_resp_valid} !== 2'b00) begin n_miss++; $display("FAIL rd_busy_t1: got %b want 00", {ifu_req_ready, ifu_resp_valid}); end
    step();
    n_vec++; if (mem_ren !== 1'b0) begin n_miss++; $display("FAIL rd_strobe_t2: got %0h want 0", mem_ren); end
    n_vec++; if (ifu_resp_valid !== 1'b1) begin n_miss++; $display("FAIL rd_resp_valid: got %0h want 1", ifu_resp_valid); end
    n_vec++; if (ifu_rdata !== 32'h0000_0413) begin n_miss++; $display("FAIL rd_rdata: got %h want 00000413", ifu_rdata); end
    ifu_resp_ready = 1'b1;
    step();
    ifu_resp_ready = 1'b0;
    #1;
    n_vec++; if ({ifu_resp_valid, dbg_state} !== 3'b000) begin n_miss++; $display("FAIL rd_done: got %b want 000", {ifu_resp_valid, dbg_state}); end
  endtask

  task automatic test_lsu_write();
    lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 8'h0F;
    lsu_req_wen = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin n_miss++; $display("FAIL wr_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
    step();
    lsu_req_valid = 1'b0;
    lsu_wdata = 32'h0;
    lsu_addr = 32'h0;
    #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b01) begin n_miss++; $display("FAIL wr_strobe_t1: got %b want 01", {mem_ren, mem_wen}); end
    n_vec++; if (mem_waddr !== 32'h8000_0100) begin n_miss++; $display("FAIL wr_waddr: got %h want 80000100", mem_waddr); end
    n_vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
    n_vec++; if (mem_wmask !== 8'h0F) begin n_miss++; $display("FAIL wr_wmask: got %h want 0f", mem_wmask); end
    step();
    n_vec++; if (mem_wen !== 1'b0) begin n_miss++; $display("FAIL wr_strobe_t2: got %0h want 0", mem_wen); end
    n_vec++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin n_miss++; $display("FAIL wr_resp_valid: got %b want 10", {lsu_resp_valid, ifu_resp_valid}); end
    n_vec++; if (lsu_rdata !== 32'h0) begin n_miss++; $display("FAIL wr_rdata: got %h want 0", lsu_rdata); end
    ifu_resp_ready = 1'b1;
    step();
    n_vec++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin n_miss++; $display("FAIL wr_nonowner_ready: got %b want 10", {lsu_resp_valid, ifu_resp_valid}); end
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b1;
    step();
    lsu_resp_ready = 1'b0;
    lsu_req_wen = 1'b0;
    #1;
    n_vec++; if (lsu_resp_valid !== 1'b0) begin n_miss++; $display("FAIL wr_done: got %0h want 0", lsu_resp_valid); end
  endtask

  task automatic test_contention();
    logic        exp_ifu;
    logic [31:0] exp_addr, exp_data;
    logic [7:0]  exp_mask;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_ifu  = (i != 1);
      exp_addr = (i == 0) ? 32'h8000_0004 : (i == 1) ? 32'h8000_0200 : 32'h8000_000C;
      exp_data = (i == 0) ? 32'h7FFF_FFFB : (i == 1) ? 32'h7FFF_FDFF : 32'h7FFF_FFF3;
      exp_mask = exp_ifu ? 8'h0F : 8'hFF;
      ifu_raddr = (i == 2) ? 32'h8000_000C : 32'h8000_0004;
      lsu_addr = 32'h8000_0200;
      lsu_rmask = 8'hFF;
      lsu_req_wen = 1'b0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      n_vec++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, !exp_ifu}) begin n_miss++; $display("FAIL rr_grant%0d: got %b want %b", i, {ifu_req_ready, lsu_req_ready}, {exp_ifu, !exp_ifu}); end
      step();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      #1;
      n_vec++; if ({mem_ren, mem_wen, mem_raddr, mem_rmask} !== {2'b10, exp_addr, exp_mask}) begin n_miss++; $display("FAIL rr_mem%0d: got %b %h %h want 10 %h %h", i, {mem_ren, mem_wen}, mem_raddr, mem_rmask, exp_addr, exp_mask); end
      step();
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== {exp_ifu, !exp_ifu}) begin n_miss++; $display("FAIL rr_resp%0d: got %b want %b", i, {ifu_resp_valid, lsu_resp_valid}, {exp_ifu, !exp_ifu}); end
      n_vec++; if ((exp_ifu ? ifu_rdata : lsu_rdata) !== exp_data) begin n_miss++; $display("FAIL rr_rdata%0d: got %h want %h", i, exp_ifu ? ifu_rdata : lsu_rdata, exp_data); end
      step();
    end
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
    n_vec++; if (both1 !== 0) begin n_miss++; $display("FAIL rr_dual_strobe: got %0d want 0", both1); end
  endtask

  task automatic test_stall();
    s_ifu_raddr = 32'h8000_0010;
    s_ifu_req_valid = 1'b1;
    #1;
    n_vec++; if (s_ifu_req_ready !== 1'b1) begin n_miss++; $display("FAIL st_ready: got %0h want 1", s_ifu_req_ready); end
    step();
    s_ifu_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (s_mem_ren !== (k == 2)) begin n_miss++; $display("FAIL st_strobe_c%0d: got %0h want %0h", k + 1, s_mem_ren, (k == 2)); end
      if (k < 2) step();
    end
    s_ifu_raddr = 32'h8000_0020;
    s_ifu_req_valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if ({s_ifu_resp_valid, s_ifu_req_ready, s_mem_ren} !== 3'b100) begin n_miss++; $display("FAIL st_hold%0d_ctrl: got %b want 100", k, {s_ifu_resp_valid, s_ifu_req_ready, s_mem_ren}); end
      n_vec++; if (s_ifu_rdata !== 32'h7FFF_FFEF) begin n_miss++; $display("FAIL st_hold%0d_rdata: got %h want 7fffffef", k, s_ifu_rdata); end
      if (k < 4) step();
    end
    s_ifu_resp_ready = 1'b1;
    step();
    n_vec++; if ({s_ifu_resp_valid, s_ifu_req_ready} !== 2'b01) begin n_miss++; $display("FAIL st_release: got %b want 01", {s_ifu_resp_valid, s_ifu_req_ready}); end
    step();
    s_ifu_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (s_mem_ren !== (k == 2)) begin n_miss++; $display("FAIL st_strobe2_c%0d: got %0h want %0h", k + 1, s_mem_ren, (k == 2)); end
      if (k < 2) step();
    end
    step();
    n_vec++; if (s_ifu_rdata !== 32'h7FFF_FFDF) begin n_miss++; $display("FAIL st_rdata2: got %h want 7fffffdf", s_ifu_rdata); end
    step();
    s_ifu_resp_ready = 1'b0;
    n_vec++; if (b2b3 !== 0) begin n_miss++; $display("FAIL st_b2b_ren: got %0d want 0", b2b3); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    s_ifu_raddr = 32'h8000_0030;
    s_ifu_req_valid = 1'b1;
    #1;
    n_vec++; if (s_ifu_req_ready !== 1'b1) begin n_miss++; $display("FAIL rm_ready: got %0h want 1", s_ifu_req_ready); end
    step();
    s_ifu_req_valid = 1'b0;
    #1;
    n_vec++; if ({s_dbg_state, s_mem_ren} !== 3'b010) begin n_miss++; $display("FAIL rm_access: got %b want 010", {s_dbg_state, s_mem_ren}); end
    rst_n = 1'b0;
    ifu_raddr = 32'h8000_0040;
    ifu_req_valid = 1'b1;
    #1;
    n_vec++; if ({s_dbg_state, s_mem_ren, s_mem_wen} !== 4'b0000) begin n_miss++; $display("FAIL rm_outs: got %b want 0000", {s_dbg_state, s_mem_ren, s_mem_wen}); end
    n_vec++; if ({s_ifu_rdata, s_mem_raddr} !== 64'h0) begin n_miss++; $display("FAIL rm_regs: got %h want 0", {s_ifu_rdata, s_mem_raddr}); end
    n_vec++; if (ifu_req_ready !== 1'b0) begin n_miss++; $display("FAIL rm_ready_in_rst: got %0h want 0", ifu_req_ready); end
    step();
    rst_n = 1'b1;
    #1;
    n_vec++; if (ifu_req_ready !== 1'b1) begin n_miss++; $display("FAIL rm_first_ready: got %0h want 1", ifu_req_ready); end
    step();
    ifu_req_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    #1;
    n_vec++; if ({mem_ren, mem_raddr} !== {1'b1, 32'h8000_0040}) begin n_miss++; $display("FAIL rm_first_accept: got %0h %h want 1 80000040", mem_ren, mem_raddr); end
    for (int k = 0; k < 6; k++) begin
      if (s_mem_ren || s_mem_wen || s_ifu_resp_valid || s_lsu_resp_valid) seen++;
      step();
    end
    n_vec++; if (seen !== 0) begin n_miss++; $display("FAIL rm_dropped: got %0d active cycles want 0", seen); end
    n_vec++; if (ifu_rdata !== 32'h7FFF_FFBF) begin n_miss++; $display("FAIL rm_rdata: got %h want 7fffffbf", ifu_rdata); end
    ifu_resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_contention();
    test_stall();
    test_reset_mid();
    n_vec++; if ({both1, b2b1, both3} !== 96'h0) begin n_miss++; $display("FAIL strobe_rules: got %0d %0d %0d want 0 0 0", both1, b2b1, both3); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
